// File: rtl/wb_ctrl.sv
// wb_ctrl: writeback controller that owns the regfile write port, merging ex and long-latency results.
// Optional build macro WB_LU_BYPASS_EN: a long result at an empty queue with no ex write goes straight to the port.
module wb_ctrl #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_we_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_waddr_i,
  input  logic [31:0] lu_wdata_i,
  output logic        lu_ready_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_waddr_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic [31:0] busy_o
);
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LQ_DEPTH);

  logic [4:0]       lq_addr_q [LQ_DEPTH];
  logic [31:0]      lq_data_q [LQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      busy_q, busy_d;

  logic       ex_req;
  logic       q_empty;
  logic       lu_keep;
  logic       bypass;
  logic       push;
  logic       pop;
  logic       lu_load;
  logic [4:0] lu_load_addr;

  // Handshake: a long result transfers on a cycle where lu_valid_i && lu_ready_o;
  // ready depends only on the registered count, never on valid.
  assign lu_ready_o = rst_n & (cnt_q < DEPTH_C);
  assign ex_req     = ex_we_i & (ex_waddr_i != 5'd0);
  assign q_empty    = (cnt_q == '0);
  assign lu_keep    = lu_valid_i & lu_ready_o & (lu_waddr_i != 5'd0);
  assign pop        = ~ex_req & ~q_empty;

`ifdef WB_LU_BYPASS_EN
  assign bypass = ~ex_req & q_empty & lu_keep;
`else
  assign bypass = 1'b0;
`endif

  assign push = lu_keep & ~bypass;

  always_comb begin
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    lu_load      = 1'b0;
    lu_load_addr = lq_addr_q[rd_ptr_q];
    if (ex_req) begin
      we_d    = 1'b1;
      waddr_d = ex_waddr_i;
      wdata_d = ex_wdata_i;
    end else if (pop) begin
      we_d    = 1'b1;
      waddr_d = lq_addr_q[rd_ptr_q];
      wdata_d = lq_data_q[rd_ptr_q];
      lu_load = 1'b1;
    end else if (bypass) begin
      we_d         = 1'b1;
      waddr_d      = lu_waddr_i;
      wdata_d      = lu_wdata_i;
      lu_load      = 1'b1;
      lu_load_addr = lu_waddr_i;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  // Clear first, then set, so a fresh issue for the same register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (lu_load) busy_d[lu_load_addr] = 1'b0;
    if (issue_i) busy_d[issue_waddr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
      busy_q   <= 32'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lq_addr_q[wr_ptr_q] <= lu_waddr_i;
      lq_data_q[wr_ptr_q] <= lu_wdata_i;
    end
  end

  assign reg_we_o    = we_q;
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;
  assign busy_o      = busy_q;
endmodule
